// File: rtl/pipelined_decode_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_decode_stage_pkg
// Description : Shared types and helpers for the pipelined decode stage:
//               function-type enum, function-code constants, the registered
//               decoded bundle, and instruction field-slice / decode helpers.
//               Instruction layout:
//                 [31:30] FUNTYPE  [29:28] FUNCODE  [27:24] RD
//                 [23:20] RS       [19:16] RX       [0]     selimm
// Revision    : 1.0  initial release
// ============================================================================
package pipelined_decode_stage_pkg;

  typedef enum logic [1:0] {
    FT_REG = 2'b00,
    FT_MEM = 2'b01,
    FT_BR  = 2'b10,
    FT_KER = 2'b11
  } funtype_e;

  // FUNCODE values with a special meaning inside a given FUNTYPE
  localparam logic [1:0] c_fc_mov     = 2'b10;  // REG: move (OPA forced to 0)
  localparam logic [1:0] c_fc_cmp     = 2'b11;  // REG: compare RD against OPB
  localparam logic [1:0] c_fc_load    = 2'b00;  // MEM: load
  localparam logic [1:0] c_fc_store   = 2'b01;  // MEM: store (reads RD)
  localparam logic [1:0] c_fc_cachewr = 2'b01;  // KER: cache write
  localparam logic [1:0] c_fc_cachesh = 2'b10;  // KER: cache shoot-down

  typedef struct packed {
    funtype_e   funtype;
    logic [1:0] funcode;
    logic [3:0] rd;
    logic       sel_wb;
    logic       memrd;
    logic       memwr;
    logic       cachewr;
    logic       cachesh;
    logic       branch;
  } decoded_bundle_t;

  function automatic funtype_e f_funtype(input logic [31:0] instr);
    return funtype_e'(instr[31:30]);
  endfunction

  function automatic logic [1:0] f_funcode(input logic [31:0] instr);
    return instr[29:28];
  endfunction

  function automatic logic [3:0] f_rd(input logic [31:0] instr);
    return instr[27:24];
  endfunction

  function automatic logic [3:0] f_rs(input logic [31:0] instr);
    return instr[23:20];
  endfunction

  function automatic logic [3:0] f_rx(input logic [31:0] instr);
    return instr[19:16];
  endfunction

  function automatic logic f_selimm(input logic [31:0] instr);
    return instr[0];
  endfunction

  // OPA is a constant zero for MOV and every kernel op; otherwise reg[A]
  function automatic logic f_uses_opa(input logic [31:0] instr);
    funtype_e   ft;
    logic [1:0] fc;
    ft = f_funtype(instr);
    fc = f_funcode(instr);
    return !((ft == FT_REG && fc == c_fc_mov) || ft == FT_KER);
  endfunction

  // Compare is the only REG op without writeback; it compares RD, not RS
  function automatic logic [3:0] f_src_a(input logic [31:0] instr);
    if (f_funtype(instr) == FT_REG && f_funcode(instr) == c_fc_cmp)
      return f_rd(instr);
    return f_rs(instr);
  endfunction

  function automatic logic f_is_store(input logic [31:0] instr);
    return f_funtype(instr) == FT_MEM && f_funcode(instr) == c_fc_store;
  endfunction

  function automatic decoded_bundle_t f_decode(input logic [31:0] instr);
    decoded_bundle_t d;
    funtype_e        ft;
    logic [1:0]      fc;
    ft        = f_funtype(instr);
    fc        = f_funcode(instr);
    d.funtype = ft;
    d.funcode = fc;
    d.rd      = f_rd(instr);
    d.sel_wb  = (ft == FT_REG && fc != c_fc_cmp) ||
                (ft == FT_MEM && fc == c_fc_load) ||
                (ft == FT_BR) ||
                (ft == FT_KER && !fc[0]);
    d.memrd   = (ft == FT_MEM && fc == c_fc_load);
    d.memwr   = (ft == FT_MEM && fc == c_fc_store);
    d.cachewr = (ft == FT_KER && fc == c_fc_cachewr);
    d.cachesh = (ft == FT_KER && fc == c_fc_cachesh);
    d.branch  = (ft == FT_BR);
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipelined_decode_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_decode_stage_if
// Description : Bus bundle for the decode stage: fetch handshake, writeback
//               port, flush, and the decoded-bundle handshake to execute.
//               master = environment (fetch/execute/writeback side)
//               slave  = decode stage
// Ports       : in_valid/in_ready/in_instr/in_pc     fetch side
//               wb_valid/wb_rd/wb_data               writeback
//               flush                                kill held + incoming
//               out_valid/out_ready/out_*            execute side
// Revision    : 1.0  initial release
// ============================================================================
interface pipelined_decode_stage_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_instr;
  logic [DATA_W-1:0] in_pc;
  logic              wb_valid;
  logic [3:0]        wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_opa;
  logic [DATA_W-1:0] out_opb;
  logic [DATA_W-1:0] out_str_data;
  logic [DATA_W-1:0] out_pc;
  logic [DATA_W-1:0] out_br_target;
  logic [3:0]        out_rd;
  logic [1:0]        out_funtype;
  logic [1:0]        out_funcode;
  logic              out_sel_wb;
  logic              out_sel_memrd;
  logic              out_sel_memwr;
  logic              out_sel_cachewr;
  logic              out_sel_cachesh;
  logic              out_sel_branch;

  modport master (
    output in_valid, in_instr, in_pc, wb_valid, wb_rd, wb_data, flush, out_ready,
    input  in_ready, out_valid, out_opa, out_opb, out_str_data, out_pc,
           out_br_target, out_rd, out_funtype, out_funcode, out_sel_wb,
           out_sel_memrd, out_sel_memwr, out_sel_cachewr, out_sel_cachesh,
           out_sel_branch
  );

  modport slave (
    input  in_valid, in_instr, in_pc, wb_valid, wb_rd, wb_data, flush, out_ready,
    output in_ready, out_valid, out_opa, out_opb, out_str_data, out_pc,
           out_br_target, out_rd, out_funtype, out_funcode, out_sel_wb,
           out_sel_memrd, out_sel_memwr, out_sel_cachewr, out_sel_cachesh,
           out_sel_branch
  );
endinterface
`default_nettype wire

// File: rtl/pipelined_decode_stage_regfile.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_decode_stage_regfile
// Description : Architectural register file, 1 write / 3 read ports.
//               Index >= NREGS reads 0 and is never written. Index PC_IDX
//               always reads i_pc and ignores writes. With BYPASS_EN a read
//               of the register being written this cycle returns i_wd.
// Ports       : clk, rst              clock, synchronous active-high reset
//               i_we/i_wa/i_wd        write port
//               i_pc                  PC mirror value
//               i_ra[3] / o_rd[3]     read addresses / read data
// Revision    : 1.0  initial release
// ============================================================================
module pipelined_decode_stage_regfile
  import pipelined_decode_stage_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int NREGS     = 16,
  parameter int PC_IDX    = 14,
  parameter int BYPASS_EN = 1
) (
  input  wire logic                   clk,
  input  wire logic                   rst,
  input  wire logic                   i_we,
  input  wire logic [3:0]             i_wa,
  input  wire logic [DATA_W-1:0]      i_wd,
  input  wire logic [DATA_W-1:0]      i_pc,
  input  wire logic [2:0][3:0]        i_ra,
  output      logic [2:0][DATA_W-1:0] o_rd
);

  localparam logic [3:0] c_pc_idx = 4'(PC_IDX);

  logic [DATA_W-1:0] r_mem [16];

  function automatic logic f_in_range(input logic [3:0] idx);
    return int'({28'd0, idx}) < NREGS;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) r_mem[i] <= '0;
    end else if (i_we && f_in_range(i_wa) && i_wa != c_pc_idx) begin
      r_mem[i_wa] <= i_wd;
    end
  end

  always_comb begin
    o_rd = '0;
    for (int p = 0; p < 3; p++) begin
      if (!f_in_range(i_ra[p]))
        o_rd[p] = '0;
      else if (i_ra[p] == c_pc_idx)
        o_rd[p] = i_pc;
      else if (BYPASS_EN != 0 && i_we && i_wa == i_ra[p])
        o_rd[p] = i_wd;
      else
        o_rd[p] = r_mem[i_ra[p]];
    end
  end

endmodule
`default_nettype wire

// File: rtl/pipelined_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_decode_stage
// Description : Registered, handshaked decode stage between fetch and execute.
//               Decodes one instruction per cycle into a 1-deep output
//               register, reads operands from the register file, tracks
//               in-flight writes in a per-register busy scoreboard and stalls
//               fetch on RAW/WAW hazards. Taken-branch flush kills the held
//               bundle and refuses the incoming one.
// Ports       : clk      clock, rising edge
//               rst      synchronous active-high reset
//               bus      slave side of pipelined_decode_stage_if
// Revision    : 1.0  initial release
// ============================================================================
module pipelined_decode_stage
  import pipelined_decode_stage_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int NREGS     = 16,
  parameter int PC_IDX    = 14,
  parameter int BYPASS_EN = 1
) (
  input wire logic clk,
  input wire logic rst,
  pipelined_decode_stage_if.slave bus
);

  // ---------------- decode of the incoming instruction ----------------
  decoded_bundle_t   w_dec;
  logic [3:0]        w_src_a;
  logic [3:0]        w_rx;
  logic              w_selimm;
  logic              w_uses_a;
  logic              w_is_store;
  logic [DATA_W-1:0] w_imm;

  assign w_dec      = f_decode(bus.in_instr);
  assign w_src_a    = f_src_a(bus.in_instr);
  assign w_rx       = f_rx(bus.in_instr);
  assign w_selimm   = f_selimm(bus.in_instr);
  assign w_uses_a   = f_uses_opa(bus.in_instr);
  assign w_is_store = f_is_store(bus.in_instr);

  always_comb begin
    w_imm = '0;
    case (w_dec.funtype)
      FT_BR:   w_imm = DATA_W'(bus.in_instr[27:0]);
      FT_REG:  w_imm = DATA_W'(bus.in_instr[19:1]);
      default: w_imm = DATA_W'(bus.in_instr[23:20]);
    endcase
  end

  // ---------------- register file ----------------
  logic [2:0][DATA_W-1:0] w_rd_data;

  pipelined_decode_stage_regfile #(
    .DATA_W   (DATA_W),
    .NREGS    (NREGS),
    .PC_IDX   (PC_IDX),
    .BYPASS_EN(BYPASS_EN)
  ) u_regfile (
    .clk  (clk),
    .rst  (rst),
    .i_we (bus.wb_valid),
    .i_wa (bus.wb_rd),
    .i_wd (bus.wb_data),
    .i_pc (bus.in_pc),
    .i_ra ({w_dec.rd, w_rx, w_src_a}),
    .o_rd (w_rd_data)
  );

  logic [DATA_W-1:0] w_opa;
  logic [DATA_W-1:0] w_opb;
  assign w_opa = w_uses_a ? w_rd_data[0] : '0;
  assign w_opb = w_selimm ? w_imm : w_rd_data[1];

  // ---------------- output register state ----------------
  logic              r_out_valid;
  decoded_bundle_t   r_ctl;
  logic [DATA_W-1:0] r_opa;
  logic [DATA_W-1:0] r_opb;
  logic [DATA_W-1:0] r_str;
  logic [DATA_W-1:0] r_pc;
  logic [DATA_W-1:0] r_tgt;
  logic [15:0]       r_busy;

  // ---------------- hazard detection ----------------
  // Per-register blocking masks. A source is blocked if it is busy (unless
  // the busy bit is being retired by writeback this cycle and bypass is on),
  // if bypass is off and writeback targets it this cycle (regfile would
  // return the stale value), or if the held bundle will write it. PC mirror
  // and out-of-range indices never block a read. Destinations block on busy
  // or held-writer regardless of writeback.
  logic [15:0] w_held;
  logic [15:0] w_wb_hit;
  logic [15:0] w_src_blk;
  logic [15:0] w_dst_blk;
  logic        w_hazard;

  always_comb begin
    w_held    = '0;
    w_wb_hit  = '0;
    w_src_blk = '0;
    w_dst_blk = '0;
    for (int i = 0; i < 16; i++) begin
      w_held[i]    = r_out_valid && r_ctl.sel_wb && (r_ctl.rd == 4'(i));
      w_wb_hit[i]  = bus.wb_valid && (bus.wb_rd == 4'(i));
      w_src_blk[i] = (i < NREGS) && (i != PC_IDX) &&
                     ((r_busy[i] && !(BYPASS_EN != 0 && w_wb_hit[i])) ||
                      (BYPASS_EN == 0 && w_wb_hit[i]) ||
                      w_held[i]);
      w_dst_blk[i] = (i < NREGS) && (r_busy[i] || w_held[i]);
    end
  end

  assign w_hazard = bus.in_valid &&
                    ((w_uses_a   && w_src_blk[w_src_a])  ||
                     (!w_selimm  && w_src_blk[w_rx])     ||
                     (w_is_store && w_src_blk[w_dec.rd]) ||
                     (w_dec.sel_wb && w_dst_blk[w_dec.rd]));

  logic w_accept;
  logic w_leave;

  assign bus.in_ready = !rst && !bus.flush && !w_hazard &&
                        (!r_out_valid || bus.out_ready);
  assign w_accept     = bus.in_valid && bus.in_ready;
  // A flushed bundle never counts as delivered
  assign w_leave      = r_out_valid && bus.out_ready && !bus.flush;

  // ---------------- scoreboard ----------------
  logic [15:0] w_busy_nxt;

  always_comb begin
    w_busy_nxt = r_busy;
    if (bus.wb_valid)
      w_busy_nxt[bus.wb_rd] = 1'b0;
    // set after clear: a same-cycle set and clear on one register leaves it busy
    if (w_leave && r_ctl.sel_wb && int'({28'd0, r_ctl.rd}) < NREGS)
      w_busy_nxt[r_ctl.rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) r_busy <= '0;
    else     r_busy <= w_busy_nxt;
  end

  // ---------------- output register ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_ctl       <= '0;
      r_opa       <= '0;
      r_opb       <= '0;
      r_str       <= '0;
      r_pc        <= '0;
      r_tgt       <= '0;
    end else if (bus.flush) begin
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_ctl       <= w_dec;
      r_opa       <= w_opa;
      r_opb       <= w_opb;
      r_str       <= w_rd_data[2];
      r_pc        <= bus.in_pc;
      r_tgt       <= bus.in_pc + w_opb;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.out_valid       = r_out_valid;
  assign bus.out_opa         = r_opa;
  assign bus.out_opb         = r_opb;
  assign bus.out_str_data    = r_str;
  assign bus.out_pc          = r_pc;
  assign bus.out_br_target   = r_tgt;
  assign bus.out_rd          = r_ctl.rd;
  assign bus.out_funtype     = r_ctl.funtype;
  assign bus.out_funcode     = r_ctl.funcode;
  assign bus.out_sel_wb      = r_ctl.sel_wb;
  assign bus.out_sel_memrd   = r_ctl.memrd;
  assign bus.out_sel_memwr   = r_ctl.memwr;
  assign bus.out_sel_cachewr = r_ctl.cachewr;
  assign bus.out_sel_cachesh = r_ctl.cachesh;
  assign bus.out_sel_branch  = r_ctl.branch;

endmodule
`default_nettype wire
